// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg
// Shared definitions for the ID-stage branch controller:
//   - br_op_e     : branch opcode encodings carried on br_op
//   - state_e     : branch wait FSM state encoding
//   - br_cond_t   : the six branch conditions produced by cmp_unit
//   - CNT_W_DEF   : default performance counter width
//   - WAIT_W      : width of the wait watchdog counter
package branch_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic eq;
    logic ne;
    logic lez;
    logic gtz;
    logic ltz;
    logic gez;
  } br_cond_t;

  localparam int CNT_W_DEF = 32;
  localparam int WAIT_W    = 8;

endpackage

// File: rtl/branch_ctrl_cmp_unit.sv
// cmp_unit
// Purely combinational branch comparator. Produces every condition the
// branch controller can select; the controller picks one by opcode.
// Ports:
//   i_rs   [31:0]  rs operand
//   i_rt   [31:0]  rt operand (only used by eq/ne)
//   o_cond         eq, ne, lez, gtz, ltz, gez
module cmp_unit
  import branch_ctrl_pkg::*;
(
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output br_cond_t    o_cond
);

  logic w_rs_zero;
  logic w_rs_neg;

  assign w_rs_zero = (i_rs == 32'd0);
  assign w_rs_neg  = i_rs[31];

  // Signed compares against zero reduce to the sign bit and a zero test.
  assign o_cond.eq  = (i_rs == i_rt);
  assign o_cond.ne  = (i_rs != i_rt);
  assign o_cond.lez = w_rs_neg | w_rs_zero;
  assign o_cond.gtz = ~w_rs_neg & ~w_rs_zero;
  assign o_cond.ltz = w_rs_neg;
  assign o_cond.gez = ~w_rs_neg;

endmodule

// File: rtl/branch_ctrl_sat_counter.sv
// sat_counter
// Generic up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears count)
//   i_inc        increment request this cycle
//   o_cnt [W-1:0] current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_inc && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl
// ID-stage branch resolution for the pipelined MIPS core. Decodes br_op,
// holds the branch while its operands are not yet forwarded, resolves it
// combinationally once they are, and keeps the delay-slot flag, a wait
// watchdog and saturating performance counters.
// Ports:
//   clk, reset                 clock / async active-high reset
//   id_valid, br_op            instruction in ID and its branch opcode
//   rs_val, rt_val             forwarded operands
//   rs_ready, rt_ready         operand finality flags
//   ext_stall, flush           other hazard stall / ID flush
//   pc_id, imm16               branch PC and offset field
//   stall, taken, npc          combinational stall request, outcome, target
//   in_delay_slot, timeout     registered delay-slot flag / sticky watchdog
//   br_cnt, taken_cnt, stall_cnt  saturating performance counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             ext_stall,
  input  logic             flush,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  output logic             stall,
  output logic             taken,
  output logic [31:0]      npc,
  output logic             in_delay_slot,
  output logic             timeout,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_inc;
  logic               r_timeout;
  logic               r_in_ds;

  br_op_e   w_op;
  br_cond_t w_cond;
  logic     w_valid_op;
  logic     w_need_rt;
  logic     w_cond_sel;
  logic     w_is_br;
  logic     w_ops_ready;
  logic     w_resolve;

  assign w_op = br_op_e'(br_op);

  cmp_unit u_cmp (
    .i_rs   (rs_val),
    .i_rt   (rt_val),
    .o_cond (w_cond)
  );

  // Opcode decode. NOTE: every signal written here gets a default first so
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_valid_op = 1'b0;
    w_need_rt  = 1'b0;
    w_cond_sel = 1'b0;
    case (w_op)
      BR_BEQ:  begin w_valid_op = 1'b1; w_need_rt = 1'b1; w_cond_sel = w_cond.eq;  end
      BR_BNE:  begin w_valid_op = 1'b1; w_need_rt = 1'b1; w_cond_sel = w_cond.ne;  end
      BR_BLEZ: begin w_valid_op = 1'b1; w_cond_sel = w_cond.lez; end
      BR_BGTZ: begin w_valid_op = 1'b1; w_cond_sel = w_cond.gtz; end
      BR_BLTZ: begin w_valid_op = 1'b1; w_cond_sel = w_cond.ltz; end
      BR_BGEZ: begin w_valid_op = 1'b1; w_cond_sel = w_cond.gez; end
      default: ;  // BR_NONE and the reserved code are not branches
    endcase
  end

  assign w_is_br     = id_valid && w_valid_op && !flush;
  assign w_ops_ready = rs_ready && (!w_need_rt || rt_ready);
  assign w_resolve   = w_is_br && w_ops_ready && !ext_stall;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state. A ready branch blocked only by ext_stall stays in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (stall) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_resolve || !id_valid || flush) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Resolution is zero-latency, so these depend on inputs only.
  always_comb begin
    stall = w_is_br && !w_ops_ready;
    taken = w_resolve && w_cond_sel;
    npc   = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  end

  // Wait watchdog: counts cycles spent in WAIT. The cycle being counted is
  // a WAIT cycle even if it is also the one that leaves WAIT, so the
  // timeout check uses the incremented value before the clear-on-exit.
  assign w_wait_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= (w_state_nxt == ST_WAIT) ? w_wait_inc : '0;
      if (w_wait_inc == MAX_WAIT_C) r_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Delay-slot flag: the instruction after any resolved branch sits in the
  // slot; a plain advance clears it; a stalled ID holds it; flush wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_in_ds <= 1'b0;
    else if (flush)
      r_in_ds <= 1'b0;
    else if (w_resolve)
      r_in_ds <= 1'b1;
    else if (id_valid && !stall && !ext_stall)
      r_in_ds <= 1'b0;
  end

  assign in_delay_slot = r_in_ds;
  assign timeout       = r_timeout;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk), .reset (reset), .i_inc (w_resolve), .o_cnt (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk), .reset (reset), .i_inc (taken), .o_cnt (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .reset (reset), .i_inc (stall), .o_cnt (stall_cnt)
  );

endmodule
